// File: rtl/conv_pkg.sv
// Shared types and sizes for the conv layer scheduler.
// Window positions are {row, col} inside an 8x8 tile.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FLUSH,
    DONE
  } sched_state_t;

  localparam int N_POS  = 64;
  localparam int POS_W  = 6;
  localparam int KSEL_W = 2;
  localparam int RES_W  = 16;
  localparam int ADDR_W = KSEL_W + POS_W;

  localparam logic [POS_W-1:0] POS_LAST =
    POS_W'(N_POS - 1);

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// MAC issue, MAC result and output-buffer signals of the
// layer scheduler; master is the scheduler side.
interface conv_layer_scheduler_if;
  import conv_pkg::*;

  logic [POS_W-1:0]  win_addr;
  logic [KSEL_W-1:0] kernel_sel;
  logic              mac_valid;
  logic              mac_ready;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output win_addr, kernel_sel, mac_valid,
    output out_valid, out_data, out_addr,
    input  mac_ready, res_valid, res_data,
    input  out_ready
  );

  modport slave (
    input  win_addr, kernel_sel, mac_valid,
    input  out_valid, out_data, out_addr,
    output mac_ready, res_valid, res_data,
    output out_ready
  );

endinterface

// File: rtl/conv_result_fifo.sv
// First-word-fall-through result FIFO; push and pop may
// coincide even when full or empty.
module conv_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Credits upstream must make an unpaired push into a full FIFO impossible.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && full && !pop)
  );

endmodule

// File: rtl/conv_layer_scheduler.sv
// Walks every window position for each kernel, issuing to the
// MAC under a credit limit and streaming results with addresses.
module conv_layer_scheduler
  import conv_pkg::*;
#(
  parameter int N_KERNELS    = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  conv_layer_scheduler_if.master bus
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] CREDITS =
    IW'(MAX_INFLIGHT);
  localparam logic [KSEL_W-1:0] KERN_LAST =
    KSEL_W'(N_KERNELS - 1);

  sched_state_t      state;
  logic [POS_W-1:0]  pos;
  logic [KSEL_W-1:0] kern;
  logic [POS_W-1:0]  out_pos;
  logic [KSEL_W-1:0] out_kern;
  logic [IW-1:0]     inflight;
  logic [IW-1:0]     inflight_n;
  logic              mac_valid_q;

  logic              live;
  logic              flushing;
  logic              issue_hs;
  logic              out_hs;
  logic              last_issue;
  logic              out_valid;
  logic [1:0]        discard;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [RES_W-1:0]  fifo_dout;

  assign live     = (state == ISSUE) || (state == DRAIN);
  assign flushing = (state == FLUSH);
  assign issue_hs = mac_valid_q && bus.mac_ready;
  assign out_hs   = out_valid && bus.out_ready;

  assign last_issue = issue_hs && (pos == POS_LAST)
                   && (kern == KERN_LAST);

  // Results are kept only while a layer is live.
  assign fifo_push = live && bus.res_valid;
  assign fifo_pop  = flushing ? !fifo_empty : out_hs;

  assign discard = flushing
    ? {1'b0, !fifo_empty} + {1'b0, bus.res_valid}
    : 2'd0;

  assign inflight_n = inflight + IW'(issue_hs)
                    - IW'(out_hs) - IW'(discard);

  assign out_valid      = live && !fifo_empty;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? fifo_dout : '0;
  assign bus.out_addr   = {out_kern, out_pos};
  assign bus.win_addr   = pos;
  assign bus.kernel_sel = kern;
  assign bus.mac_valid  = mac_valid_q;

  conv_result_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus.res_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pos         <= '0;
      kern        <= '0;
      out_pos     <= '0;
      out_kern    <= '0;
      inflight    <= '0;
      mac_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      inflight <= inflight_n;
      done     <= 1'b0;

      if (out_hs) begin
        if (out_pos == POS_LAST) begin
          out_pos  <= '0;
          out_kern <= out_kern + 1'b1;
        end else begin
          out_pos <= out_pos + 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          pos      <= '0;
          kern     <= '0;
          out_pos  <= '0;
          out_kern <= '0;
          if (start) begin
            state       <= ISSUE;
            mac_valid_q <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_hs) begin
            if (pos == POS_LAST) begin
              pos  <= '0;
              kern <= (kern == KERN_LAST)
                    ? '0 : kern + 1'b1;
            end else begin
              pos <= pos + 1'b1;
            end
          end
          if (abort) begin
            state       <= FLUSH;
            mac_valid_q <= 1'b0;
          end else if (last_issue) begin
            state       <= DRAIN;
            mac_valid_q <= 1'b0;
          end else begin
            mac_valid_q <= (inflight_n < CREDITS);
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= FLUSH;
          end else if (inflight_n == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        FLUSH: begin
          if (inflight == '0 && fifo_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
Sequences the 3x3 window extractor and a pipelined MAC unit across all window positions of an 8x8 tile, for each kernel in turn.
- Issues window addresses and kernel selects to the MAC with valid/ready flow control.
- Bounds in-flight operations with a credit counter.
- Buffers in-order MAC results and streams them to the output buffer with addresses.
- Raises a done pulse when the layer completes.

Parameters:
N_KERNELS, 3, number of kernels processed per layer (kernel_sel range 0..N_KERNELS-1)
N_POS, 64, window positions per kernel (win_addr = {row[2:0], col[2:0]})
MAX_INFLIGHT, 4, maximum MAC operations issued but not yet accepted by the output
RES_W, 16, MAC result width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a layer; sampled only in IDLE
abort  in  1  cancel the current layer; sampled in ISSUE/DRAIN
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the last result is accepted by the output
win_addr  out  6  window position to extractor/MAC
kernel_sel  out  2  kernel index to MAC
mac_valid  out  1  issue request
mac_ready  in  1  MAC accepts issue when mac_valid && mac_ready
res_valid  in  1  MAC result strobe; results return in issue order, any latency >=1
res_data  in  RES_W  MAC result
out_valid  out  1  result available to output buffer
out_ready  in  1  output accepts when out_valid && out_ready
out_data  out  RES_W  result
out_addr  out  8  kernel*N_POS + position of out_data

Behaviour:
- Reset (reset=0, asynchronous) forces the following: state=IDLE; pos, kern, inflight=0; FIFO empty; busy, done, mac_valid, out_valid=0; win_addr, kernel_sel, out_addr, out_data=0.
- States: IDLE, ISSUE, DRAIN, FLUSH, DONE.
- IDLE: when start=1, go to ISSUE next cycle with pos=0, kern=0. start while busy is ignored.
- ISSUE:
  - mac_valid = (inflight < MAX_INFLIGHT).
  - win_addr and kernel_sel are registered and equal pos and kern.
  - On a handshake, pos increments. At pos=N_POS-1, pos wraps to 0 and kern increments.
  - The handshake at pos=N_POS-1, kern=N_KERNELS-1 moves to DRAIN.
  - mac_valid never drops without a handshake unless abort is asserted or credits are exhausted.
- Credits:
  - inflight increments on an issue handshake and decrements on an output handshake.
  - A simultaneous issue and output handshake leaves inflight unchanged.
  - inflight never exceeds MAX_INFLIGHT.
- Result FIFO:
  - Depth MAX_INFLIGHT. Pushes on res_valid and pops on an output handshake.
  - Push and pop in the same cycle are allowed, including when full or empty (first-word-fall-through).
  - Credits guarantee no overflow. A res_valid while full is a protocol error, flagged by an assertion only.
- Output address: a separate out counter (kern, pos) advances per output handshake, giving out_addr = out_kern*N_POS + out_pos.
  - out_valid = FIFO not empty.
  - out_data and out_addr are stable while out_valid && !out_ready.
- DRAIN:
  - No issues.
  - When the final output handshake occurs (inflight goes 1->0), go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Then go to IDLE.
- abort in ISSUE or DRAIN:
  - mac_valid=0 next cycle and state goes to FLUSH.
  - In FLUSH, out_valid=0, and the FIFO plus incoming res_valid are discarded.
  - Each discarded result decrements inflight.
  - FLUSH goes to IDLE when inflight=0 and the FIFO is empty.
  - done is never asserted after an abort.
  - abort in IDLE or DONE is ignored.
- Latency: the first mac_valid is 1 cycle after start. Minimum layer time is N_KERNELS*N_POS + MAC latency + 2 cycles.
- Reset asserted mid-operation returns to the reset state immediately. In-flight MAC results arriving afterwards are ignored while in IDLE.

Decomposition:
- Package conv_pkg holds:
  - state typedef sched_state_t {IDLE, ISSUE, DRAIN, FLUSH, DONE}.
  - Constants N_POS=64, POS_W=6, KSEL_W=2, RES_W=16.
- Sub-module conv_result_fifo: parameterised depth/width, FWFT, same clock/reset, with push, pop, full, empty, dout.

Test Plan:
- Nominal: start=1 for 1 cycle, mac_ready=1, MAC latency 2, out_ready=1 -> 192 issues in order, win_addr 0..63 for kernel 0,1,2; out_addr 0..191; done pulses once at cycle ~196; busy low the next cycle.
- Credit stall: out_ready=0 from cycle 0 -> exactly 4 issue handshakes, then mac_valid=0 and the FIFO holds 4 results. Releasing out_ready then completes with 192 outputs and no loss.
- MAC backpressure: mac_ready toggles 1,0,1,0 -> win_addr/kernel_sel held while mac_valid && !mac_ready; no skipped or duplicated positions; wrap from pos 63/kern 0 to pos 0/kern 1 is correct.
- Abort: assert abort at issue #70 with 3 in flight -> FLUSH discards 3 results, out_valid stays 0, returns to IDLE, done never asserts. A new start then yields a clean 192-output layer.
- Async reset mid-DRAIN: drop reset between clock edges -> all outputs 0 immediately without a clock edge; stray res_valid is ignored; a subsequent start works.
- start while busy, and start held high across DONE -> no restart during busy; a new layer begins the cycle after returning to IDLE.
